fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter bits_addr, default 32, width of PC and memory address.
REQ-002 Parameter bits_data, default 32, instruction/memory word width.
REQ-003 Parameter RESET_PC, default 0, byte address of first fetch after reset.
REQ-004 clk  input  1  single clock; all state changes on posedge clk.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 mem_address  output  bits_addr  word address to the memory unit; equals {2'b00, pc_q[bits_addr-1:2]}.
REQ-007 mem_write  output  1  memory write strobe; constant 0.
REQ-008 mem_data_in  output  bits_data  memory write data; constant 0.
REQ-009 mem_data_out  input  bits_data  memory read data; 1-cycle latency (address sampled at edge N, data valid after edge N).
REQ-010 instr  output  bits_data  fetched instruction, FIFO head.
REQ-011 instr_pc  output  bits_addr  byte address of instr.
REQ-012 instr_valid  output  1  instr/instr_pc valid.
REQ-013 instr_ready  input  1  consumer accepts; transfer = instr_valid && instr_ready at posedge.
REQ-014 redirect  input  1  discard all fetched/in-flight words, restart at redirect_pc.
REQ-015 redirect_pc  input  bits_addr  new fetch byte address; bits [1:0] ignored (treated as 0).

Function
REQ-016 Internal state: pc_q (next fetch byte address), rsp_v/rsp_pc (in-flight read), 2-entry output FIFO of {instr, pc} with count 0..2.
REQ-017 occ = fifo_count + rsp_v; pop = instr_valid && instr_ready.
REQ-018 issue = !redirect && (occ < 2 || pop), combinational.
REQ-019 On posedge with issue: pc_q <= pc_q + 4 (modulo 2^bits_addr, wraps to 0), rsp_v <= 1, rsp_pc <= pc_q; without issue: pc_q held, rsp_v <= 0.
REQ-020 mem_address tracks pc_q every cycle; when not issuing the address is held, so a repeated read is harmless and ignored.
REQ-021 On posedge with rsp_v && !redirect: push {mem_data_out, rsp_pc} into FIFO.
REQ-022 Push and pop at the same edge: count unchanged, order preserved; FIFO never overflows (guaranteed by REQ-018), overflow is not handled.
REQ-023 instr_valid = (fifo_count != 0); instr/instr_pc show the oldest entry and are stable while instr_valid && !instr_ready.
REQ-024 Latency: address issued at edge N, instr_valid with that word after edge N+1; sustained throughput 1 instruction/cycle with instr_ready held high.
REQ-025 Redirect at posedge (priority over issue/push/pop): FIFO cleared, rsp_v <= 0, pc_q <= {redirect_pc[bits_addr-1:2], 2'b00}.
REQ-026 A transfer in the same cycle as redirect counts as accepted by the consumer; the FIFO is still fully flushed.
REQ-027 After redirect edge: instr_valid = 0 next cycle; first redirected word valid 2 edges later.
REQ-028 Redirect on consecutive cycles: only the last redirect_pc takes effect.

Reset
REQ-029 rst asserted: immediately (no clock) pc_q = RESET_PC with bits [1:0] forced to 0, rsp_v = 0, fifo_count = 0, instr_valid = 0, instr = 0, instr_pc = 0, mem_write = 0.
REQ-030 Reset mid-operation discards all in-flight and buffered words; the first edge after release issues RESET_PC.

Verification
REQ-031 Memory words 0..3 = A,B,C,D, RESET_PC=0, instr_ready=1, release rst -> instr_valid rises after 2nd edge with instr=A/pc=0x0, then B/0x4, C/0x8, D/0xC on consecutive cycles.
REQ-032 instr_ready=0 for 5 cycles after first valid -> instr=A/pc=0 held, mem_address stops at 2; on ready=1 -> A,B,C,... in order, no loss or duplicate.
REQ-033 FIFO full, redirect=1 with redirect_pc=0x8 -> next cycle instr_valid=0, mem_address=2; instr=C/pc=0x8 valid 2 edges after redirect edge.
REQ-034 redirect_pc=0x0000000B -> fetch resumes at pc 0x8, instr=C.
REQ-035 RESET_PC=0xFFFFFFF8, ready=1 -> instr_pc sequence 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
REQ-036 rst pulsed between edges while instr_valid=1 -> instr_valid=0 before next edge; after release fetch restarts at RESET_PC with REQ-031 timing.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch unit: streams sequential words from a 1-cycle-latency memory into a 2-entry output FIFO.
// Latency 2 edges from issue to instr_valid, 1 instr/cycle sustained; fetch stalls when FIFO + in-flight read would overflow.
module fetch_unit #(
  parameter int bits_addr = 32,
  parameter int bits_data = 32,
  parameter logic [bits_addr-1:0] RESET_PC = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic [bits_addr-1:0] mem_address,
  output logic                 mem_write,
  output logic [bits_data-1:0] mem_data_in,
  input  logic [bits_data-1:0] mem_data_out,
  output logic [bits_data-1:0] instr,
  output logic [bits_addr-1:0] instr_pc,
  output logic                 instr_valid,
  input  logic                 instr_ready,
  input  logic                 redirect,
  input  logic [bits_addr-1:0] redirect_pc
);

  localparam logic [bits_addr-1:0] ALIGN_MASK = ~bits_addr'(3);
  localparam logic [bits_addr-1:0] START_PC   = RESET_PC & ALIGN_MASK;

  logic [bits_addr-1:0] pc_q;
  logic                 rsp_v;
  logic [bits_addr-1:0] rsp_pc;
  logic [bits_data-1:0] e0_dat, e1_dat;
  logic [bits_addr-1:0] e0_pc, e1_pc;
  logic [1:0]           fifo_count;

  logic [1:0] occ;
  logic       pop, push, issue;

  assign occ   = fifo_count + {1'b0, rsp_v};
  assign pop   = instr_valid && instr_ready;
  assign push  = rsp_v && !redirect;
  // An in-flight read always has a FIFO slot reserved, so the FIFO never overflows.
  assign issue = !redirect && ((occ < 2'd2) || pop);

  assign mem_address = pc_q >> 2;
  assign mem_write   = 1'b0;
  assign mem_data_in = '0;
  assign instr       = e0_dat;
  assign instr_pc    = e0_pc;
  assign instr_valid = (fifo_count != 2'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= START_PC;
      rsp_v      <= 1'b0;
      rsp_pc     <= '0;
      e0_dat     <= '0;
      e0_pc      <= '0;
      e1_dat     <= '0;
      e1_pc      <= '0;
      fifo_count <= 2'd0;
    end else if (redirect) begin
      pc_q       <= redirect_pc & ALIGN_MASK;
      rsp_v      <= 1'b0;
      fifo_count <= 2'd0;
    end else begin
      rsp_v <= issue;
      if (issue) begin
        pc_q   <= pc_q + bits_addr'(4);
        rsp_pc <= pc_q;
      end
      if (push && pop) begin
        if (fifo_count == 2'd2) begin
          e0_dat <= e1_dat;
          e0_pc  <= e1_pc;
          e1_dat <= mem_data_out;
          e1_pc  <= rsp_pc;
        end else begin
          e0_dat <= mem_data_out;
          e0_pc  <= rsp_pc;
        end
      end else if (push) begin
        if (fifo_count == 2'd0) begin
          e0_dat <= mem_data_out;
          e0_pc  <= rsp_pc;
        end else begin
          e1_dat <= mem_data_out;
          e1_pc  <= rsp_pc;
        end
        fifo_count <= fifo_count + 2'd1;
      end else if (pop) begin
        e0_dat     <= e1_dat;
        e0_pc      <= e1_pc;
        fifo_count <= fifo_count - 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed and randomized checks of fetch_unit against a memory whose words are a hash of their address.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        instr_ready = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;

  logic [31:0] ma0, din0, md0, instr0, ipc0;
  logic        mw0, iv0;
  logic [31:0] ma1, din1, md1, instr1, ipc1;
  logic        mw1, iv1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] wf(input logic [31:0] waddr);
    return waddr * 32'h9E37_79B1 + 32'h1234_5678;
  endfunction

  always @(posedge clk) md0 <= wf(ma0);
  always @(posedge clk) md1 <= wf(ma1);

  fetch_unit #(.bits_addr(32), .bits_data(32), .RESET_PC(32'h0)) u0 (
    .clk(clk), .rst(rst),
    .mem_address(ma0), .mem_write(mw0), .mem_data_in(din0), .mem_data_out(md0),
    .instr(instr0), .instr_pc(ipc0), .instr_valid(iv0), .instr_ready(instr_ready),
    .redirect(redirect), .redirect_pc(redirect_pc)
  );

  fetch_unit #(.bits_addr(32), .bits_data(32), .RESET_PC(32'hFFFF_FFF8)) u1 (
    .clk(clk), .rst(rst),
    .mem_address(ma1), .mem_write(mw1), .mem_data_in(din1), .mem_data_out(md1),
    .instr(instr1), .instr_pc(ipc1), .instr_valid(iv1), .instr_ready(instr_ready),
    .redirect(1'b0), .redirect_pc(32'h0)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_head(input string tag, input logic [31:0] pc);
    chk({tag, "_valid"}, 64'(iv0), 64'd1);
    chk({tag, "_pc"}, 64'(ipc0), 64'(pc));
    chk({tag, "_instr"}, 64'(instr0), 64'(wf(pc >> 2)));
  endtask

  initial begin
    logic [31:0] exp_next;
    logic        prev_redir;
    logic        r_rdy, r_redir;
    logic [31:0] r_pc;
    int          transfers;

    // Reset values, before any clock edge matters
    #1 rst = 1'b1;
    #1;
    chk("rst_valid", 64'(iv0), 64'd0);
    chk("rst_instr", 64'(instr0), 64'd0);
    chk("rst_ipc", 64'(ipc0), 64'd0);
    chk("rst_addr", 64'(ma0), 64'd0);
    chk("rst_mw", 64'(mw0), 64'd0);
    chk("rst_din", 64'(din0), 64'd0);
    chk("rst_addr_hi", 64'(ma1), 64'h3FFF_FFFE);

    // Streaming from reset with ready high, both reset vectors
    @(negedge clk);
    rst = 1'b0;
    instr_ready = 1'b1;
    @(negedge clk);
    chk("lat_edge1_valid", 64'(iv0), 64'd0);
    chk("lat_edge1_addr", 64'(ma0), 64'd1);
    @(negedge clk);
    chk_head("stream_A", 32'h0);
    chk("wrap_pc0", 64'(ipc1), 64'hFFFF_FFF8);
    chk("wrap_v0", 64'(iv1), 64'd1);
    @(negedge clk);
    chk_head("stream_B", 32'h4);
    chk("wrap_pc1", 64'(ipc1), 64'hFFFF_FFFC);
    @(negedge clk);
    chk_head("stream_C", 32'h8);
    chk("wrap_pc2", 64'(ipc1), 64'h0);
    chk("wrap_instr2", 64'(instr1), 64'(wf(32'h0)));
    @(negedge clk);
    chk_head("stream_D", 32'hC);

    // Backpressure: ready low for 5 cycles after first valid
    rst = 1'b1;
    instr_ready = 1'b0;
    #2 rst = 1'b0;
    @(negedge clk);
    chk("bp_edge1_valid", 64'(iv0), 64'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk_head("bp_hold", 32'h0);
      chk("bp_addr", 64'(ma0), 64'd2);
    end
    instr_ready = 1'b1;
    for (int k = 1; k < 8; k++) begin
      @(negedge clk);
      chk_head("bp_resume", 32'(k * 4));
    end

    // Redirect with a full FIFO
    instr_ready = 1'b0;
    repeat (3) @(negedge clk);
    redirect = 1'b1;
    redirect_pc = 32'h8;
    @(negedge clk);
    redirect = 1'b0;
    instr_ready = 1'b1;
    chk("redir_valid0", 64'(iv0), 64'd0);
    chk("redir_addr", 64'(ma0), 64'd2);
    @(negedge clk);
    chk("redir_valid1", 64'(iv0), 64'd0);
    @(negedge clk);
    chk_head("redir_C", 32'h8);
    @(negedge clk);
    chk_head("redir_D", 32'hC);

    // Unaligned redirect target
    redirect = 1'b1;
    redirect_pc = 32'h0000_000B;
    @(negedge clk);
    redirect = 1'b0;
    chk("unal_valid0", 64'(iv0), 64'd0);
    chk("unal_addr", 64'(ma0), 64'd2);
    @(negedge clk);
    @(negedge clk);
    chk_head("unal_C", 32'h8);

    // Back-to-back redirects: last one wins
    redirect = 1'b1;
    redirect_pc = 32'h40;
    @(negedge clk);
    redirect_pc = 32'h80;
    @(negedge clk);
    redirect = 1'b0;
    chk("b2b_valid0", 64'(iv0), 64'd0);
    chk("b2b_addr", 64'(ma0), 64'h20);
    @(negedge clk);
    @(negedge clk);
    chk_head("b2b_head", 32'h80);

    // Reset pulse between edges while valid
    @(negedge clk);
    chk("mid_pre_valid", 64'(iv0), 64'd1);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_valid", 64'(iv0), 64'd0);
    chk("mid_rst_instr", 64'(instr0), 64'd0);
    chk("mid_rst_addr", 64'(ma0), 64'd0);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("mid_edge1_valid", 64'(iv0), 64'd0);
    chk("mid_edge1_addr", 64'(ma0), 64'd1);
    @(negedge clk);
    chk_head("mid_restart", 32'h0);

    // Randomized ready/redirect against an in-order stream model
    exp_next = 32'h0;
    prev_redir = 1'b0;
    transfers = 0;
    for (int c = 0; c < 400; c++) begin
      if (c != 0) @(negedge clk);
      if (prev_redir) chk("rnd_post_redir_valid", 64'(iv0), 64'd0);
      if (iv0) begin
        chk("rnd_pc", 64'(ipc0), 64'(exp_next));
        chk("rnd_instr", 64'(instr0), 64'(wf(exp_next >> 2)));
      end
      chk("rnd_mw", 64'(mw0), 64'd0);
      r_rdy   = ($urandom_range(3) != 0);
      r_redir = ($urandom_range(15) == 0);
      r_pc    = $urandom;
      instr_ready = r_rdy;
      redirect    = r_redir;
      redirect_pc = r_pc;
      if (iv0 && r_rdy) begin
        exp_next = exp_next + 32'd4;
        transfers++;
      end
      if (r_redir) exp_next = r_pc & ~32'd3;
      prev_redir = r_redir;
    end
    @(negedge clk);
    redirect = 1'b0;
    chk("rnd_progress", 64'(transfers > 100), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
